// File: rtl/blaster_batch_pkg.sv
// Shared types for the blaster response batcher: FSM states, flush causes
// and the pointer-width helper used to size the circular buffer.
package blaster_batch_pkg;

  typedef enum logic {
    COLLECT,
    DRAIN
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    THRESH,
    TIMER,
    FORCE
  } flush_cause_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/blaster_batch_ram.sv
// DEPTH x 8 simple dual-port RAM, synchronous write, registered read (1 clk).
// The read register holds its value when rd_vld is low, so it doubles as a stall-safe output stage.
module blaster_batch_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          wr_vld,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_dat,
  input  logic          rd_vld,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_dat
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_vld) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_dat <= 8'h00;
    end else if (rd_vld) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/blaster_resp_batcher.sv
// Batches TDO response bytes and releases bursts on threshold, latency timer or forced flush;
// first byte 1 clk after DRAIN entry, output held under i_tx_ready stall. Stats: BLASTER_BATCH_STATS_EN.
module blaster_resp_batcher
  import blaster_batch_pkg::*;
#(
  parameter int DEPTH           = 64,
  parameter int FLUSH_THRESHOLD = 16,
  parameter int LATENCY_CLKS    = 25000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_flush,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow,
  output logic [15:0]            o_timer_flushes
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] THR_LVL  = LW'(FLUSH_THRESHOLD);
  localparam logic [15:0]   LAT_LAST = 16'(LATENCY_CLKS - 1);

  state_e       state_q, state_d;
  flush_cause_e cause;

  logic          full;
  logic          wr_vld;
  logic          rd_vld;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] burst_cnt;
  logic [15:0]   timer;

  assign full    = (o_level == FULL_LVL);
  assign o_ready = ~full;
  assign wr_vld  = i_valid & ~full;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Threshold outranks a forced flush, which outranks the timer, so a
  // TIMER cause always means the timer alone fired.
  always_comb begin
    state_d = state_q;
    cause   = NONE;
    rd_vld  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (o_level >= THR_LVL) begin
          cause = THRESH;
        end else if (i_flush && (o_level != '0)) begin
          cause = FORCE;
        end else if ((o_level != '0) && (timer == LAT_LAST)) begin
          cause = TIMER;
        end
        if (cause != NONE) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        rd_vld = (burst_cnt != '0) && (!o_tx_valid || i_tx_ready);
        if ((burst_cnt == '0) && !o_tx_valid) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      burst_cnt  <= '0;
      timer      <= '0;
      o_level    <= '0;
      o_tx_valid <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (i_valid && full) begin
        o_overflow <= 1'b1;
      end
      if (rd_vld) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      o_level <= o_level + LW'(wr_vld) - LW'(rd_vld);

      // Burst size is the registered level; a same-cycle write waits for the next flush.
      if (cause != NONE) begin
        burst_cnt <= o_level;
      end else if (rd_vld) begin
        burst_cnt <= burst_cnt - 1'b1;
      end

      if ((state_q == COLLECT) && (o_level != '0) && (cause == NONE)) begin
        timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end

      if (rd_vld) begin
        o_tx_valid <= 1'b1;
      end else if (i_tx_ready) begin
        o_tx_valid <= 1'b0;
      end
    end
  end

  blaster_batch_ram #(
    .DEPTH(DEPTH),
    .AW   (PW)
  ) u_ram (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .wr_vld (wr_vld),
    .wr_addr(wr_ptr),
    .wr_dat (i_data),
    .rd_vld (rd_vld),
    .rd_addr(rd_ptr),
    .rd_dat (o_tx_data)
  );

`ifdef BLASTER_BATCH_STATS_EN
  logic [15:0] timer_flushes;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      timer_flushes <= '0;
    end else if ((cause == TIMER) && (timer_flushes != 16'hFFFF)) begin
      timer_flushes <= timer_flushes + 1'b1;
    end
  end

  assign o_timer_flushes = timer_flushes;
`else
  assign o_timer_flushes = 16'h0000;
`endif

endmodule

// File: tb/tb_blaster_resp_batcher.sv
// Directed bench for blaster_resp_batcher: per-cycle vector table for the forced-flush/stall
// sequence, plus hand-written threshold, timer, overflow, wrap and reset sequences.
module tb_blaster_resp_batcher;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic        i_flush;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [6:0]  o_level;
  logic        o_overflow;
  logic [15:0] o_timer_flushes;

  int checks   = 0;
  int failures = 0;
  logic [7:0] rx_q[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       f;
    logic       r;
    logic       e_txv;
    logic [7:0] e_dat;
    logic [6:0] e_lvl;
  } vec_t;

  vec_t tbl[10];

  blaster_resp_batcher #(
    .DEPTH          (64),
    .FLUSH_THRESHOLD(16),
    .LATENCY_CLKS   (100)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_flush        (i_flush),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (i_tx_ready),
    .o_level        (o_level),
    .o_overflow     (o_overflow),
    .o_timer_flushes(o_timer_flushes)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change at posedge+1, so the negedge sees the values that the next posedge transfers.
  always @(negedge i_clk) begin
    if (i_reset === 1'b0 && o_tx_valid === 1'b1 && i_tx_ready === 1'b1) begin
      rx_q.push_back(o_tx_data);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
    i_valid    = v;
    i_data     = d;
    i_flush    = f;
    i_tx_ready = r;
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    for (int k = 0; k < budget && rx_q.size() < n; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    check(name, rx_q.size(), n);
  endtask

  task automatic check_rx(input string name, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      check(name, (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, (base + i) & 255);
    end
  endtask

  initial begin
    logic [15:0] exp_tf;
`ifdef BLASTER_BATCH_STATS_EN
    exp_tf = 16'd1;
`else
    exp_tf = 16'd0;
`endif

    // Write 2, force flush, stall 2 cycles, flushes in DRAIN and on empty are ignored.
    tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 7'd1};
    tbl[1] = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 8'h00, 7'd2};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd2};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 7'd1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 7'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hB2, 7'd0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 7'd0};

    i_reset = 1'b1;
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    i_reset = 1'b0;
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_level", o_level, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_timer_flushes", o_timer_flushes, 0);
    check("rst_ready", o_ready, 1);

    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      check($sformatf("tbl%0d_tx_valid", i), o_tx_valid, tbl[i].e_txv);
      check($sformatf("tbl%0d_level", i), o_level, tbl[i].e_lvl);
      check($sformatf("tbl%0d_ready", i), o_ready, 1);
      if (tbl[i].e_txv) check($sformatf("tbl%0d_tx_data", i), o_tx_data, tbl[i].e_dat);
    end
    check("tbl_rx_count", rx_q.size(), 2);
    check("tbl_rx_first", rx_q.size() > 0 ? {24'h0, rx_q[0]} : 32'hDEAD, 32'hA1);

    // Threshold flush of 16 bytes.
    rx_q.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("thr_no_valid_at_entry", o_tx_valid, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("thr_first_valid", o_tx_valid, 1);
    check("thr_first_data", o_tx_data, 8'h00);
    wait_rx(16, 40, "thr_rx_count");
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("thr_rx_final_count", rx_q.size(), 16);
    check_rx("thr_rx_data", 0, 16);
    check("thr_level_after", o_level, 0);
    check("thr_no_timer_count", o_timer_flushes, 0);

    // Latency timer flush: DRAIN entry exactly 100 clocks after the first write.
    rx_q.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
    repeat (98) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("tmr_no_valid_at_entry", o_tx_valid, 0);
    check("tmr_level_at_entry", o_level, 3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("tmr_first_valid", o_tx_valid, 1);
    check("tmr_first_data", o_tx_data, 8'h30);
    wait_rx(3, 20, "tmr_rx_count");
    check_rx("tmr_rx_data", 8'h30, 3);
    check("tmr_timer_flushes", o_timer_flushes, exp_tf);

    // Fill with the transmitter stalled: 64 buffered + 1 in the output register.
    rx_q.delete();
    for (int i = 0; i < 65; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("ovf_ready_low", o_ready, 0);
    check("ovf_level_full", o_level, 64);
    check("ovf_not_yet", o_overflow, 0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    check("ovf_sticky", o_overflow, 1);
    check("ovf_level_unchanged", o_level, 64);
    repeat (5) step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("stall_valid", o_tx_valid, 1);
      check("stall_data", o_tx_data, rx_q.size() & 255);
    end
    wait_rx(65, 300, "ovf_rx_count");
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_rx_final_count", rx_q.size(), 65);
    check_rx("ovf_rx_data", 0, 65);
    check("ovf_still_sticky", o_overflow, 1);

    // Writes during DRAIN stay out of the current burst.
    rx_q.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b1);
    check("drw_level_rw_same_cycle", o_level, 16);
    wait_rx(16, 40, "drw_rx_count");
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("drw_burst_exact", rx_q.size(), 16);
    check("drw_level_left", o_level, 5);
    check_rx("drw_rx_data", 8'h80, 16);
    rx_q.delete();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    wait_rx(5, 20, "drw2_rx_count");
    check_rx("drw2_rx_data", 8'h90, 5);

    // Reset in the middle of a burst.
    rx_q.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    for (int k = 0; k < 5 && o_tx_valid !== 1'b1; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("rstm_in_burst", o_tx_valid, 1);
    i_reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    i_reset = 1'b0;
    check("rstm_tx_valid", o_tx_valid, 0);
    check("rstm_level", o_level, 0);
    check("rstm_overflow", o_overflow, 0);
    check("rstm_ready", o_ready, 1);
    check("rstm_timer_flushes", o_timer_flushes, 0);
    rx_q.delete();
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h12, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    wait_rx(2, 20, "rstm_rx_count");
    repeat (5) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rstm_no_stale", rx_q.size(), 2);
    check_rx("rstm_rx_data", 8'h11, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
